// File: rtl/tinysoc_loader_pkg.sv
// tinysoc_loader_pkg: shared types and sizes for the tinysoc ROM loader.
package tinysoc_loader_pkg;
   localparam int INSTR_W = 12;
   localparam int HALF_W = 6;
   localparam int IMEM_DEPTH = 8;
   localparam int H_W = 4;
   typedef enum logic [1:0] {IDLE, RESET, LOAD, RUN} state_t;
   function automatic logic [HALF_W-1:0] half_of(input logic [INSTR_W-1:0] w, input logic hi);
      return hi ? w[INSTR_W-1:HALF_W] : w[HALF_W-1:0];
   endfunction
endpackage

// File: rtl/tinysoc_tclk_gen.sv
// tinysoc_tclk_gen: target clock divider; strobes flag the system cycle whose edge
// makes the target clock rise or fall.
module tinysoc_tclk_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic tclk,
   output logic rise_stb,
   output logic fall_stb
);
   localparam int CW = $clog2(CLK_DIV + 1);
   logic [CW-1:0] cnt;
   logic tick;
   assign tick = run && cnt == CW'(CLK_DIV - 1);
   assign rise_stb = tick && !tclk;
   assign fall_stb = tick && tclk;
   always_ff @(posedge clk) begin
      if (rst || clear || !run) begin
         cnt <= '0;
         tclk <= 1'b0;
      end else if (tick) begin
         cnt <= '0;
         tclk <= !tclk;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/tinysoc_loader.sv
// tinysoc_loader: buffers 8 instructions, resets the target and serialises them as 6-bit
// halves, then forwards GPI/GPO. TINYSOC_LOADER_STEP_EN adds single-step run clocking.
module tinysoc_loader
   import tinysoc_loader_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int RST_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic instr_valid,
   input  logic [INSTR_W-1:0] instr_data,
   output logic instr_ready,
   input  logic start,
   input  logic abort,
   input  logic [3:0] gpi_in,
`ifdef TINYSOC_LOADER_STEP_EN
   input  logic step,
`endif
   output logic busy,
   output logic done,
   output logic [7:0] pin_out,
   input  logic [7:0] pin_in,
   output logic [3:0] gpo_out
);
   localparam int RW = $clog2(RST_CYCLES + 1);
   state_t state, state_n;
   logic [INSTR_W-1:0] mem [IMEM_DEPTH];
   logic [2:0] wptr;
   logic [3:0] count, count_n;
   logic [H_W-1:0] h, h_n, nh;
   logic [RW-1:0] rcnt, rcnt_n;
   logic [HALF_W-1:0] data, data_n, nhalf;
   logic [INSTR_W-1:0] nw;
   logic rpin, rpin_n, wr, tclk, rise, fall, gen_run;
   logic [3:0] gpo_meta;
   logic unused;
   assign unused = ^pin_in[7:4];
   assign wr = instr_valid && instr_ready;
   assign count_n = count + {3'b0, wr};
   assign pin_out = {data, rpin, tclk};
   // Half presented at the next falling edge: 0 on leaving RESET, h+1 while loading.
   assign nh = state == LOAD ? h + 1'b1 : '0;
   assign nw = {1'b0, nh[3:1]} < count ? mem[nh[3:1]] : '0;
   assign nhalf = half_of(nw, nh[0]);
`ifdef TINYSOC_LOADER_STEP_EN
   logic stepping;
   always_ff @(posedge clk) begin
      if (rst || abort || state != RUN) stepping <= 1'b0;
      else if (!stepping) stepping <= step;
      else if (fall) stepping <= 1'b0;
   end
   assign gen_run = state == RESET || state == LOAD || (state == RUN && stepping);
`else
   assign gen_run = state != IDLE;
`endif
   tinysoc_tclk_gen #(.CLK_DIV(CLK_DIV)) u_tclk (
      .clk(clk),
      .rst(rst),
      .run(gen_run),
      .clear(abort),
      .tclk(tclk),
      .rise_stb(rise),
      .fall_stb(fall)
   );
   always_comb begin
      state_n = state;
      h_n = h;
      rcnt_n = rcnt;
      data_n = data;
      rpin_n = rpin;
      case (state)
         IDLE: begin
            state_n = start ? RESET : IDLE;
            rcnt_n = '0;
         end
         RESET: begin
            rcnt_n = rise ? rcnt + 1'b1 : rcnt;
            if (fall && rcnt == RW'(RST_CYCLES)) begin
               state_n = LOAD;
               rpin_n = 1'b0;
               h_n = '0;
               data_n = nhalf;
            end
         end
         LOAD: begin
            if (fall) begin
               state_n = h == '1 ? RUN : LOAD;
               h_n = nh;
               data_n = h == '1 ? {gpi_in, 2'b00} : nhalf;
            end
         end
         default: data_n = fall ? {gpi_in, 2'b00} : data;
      endcase
      if (abort) begin
         state_n = IDLE;
         h_n = '0;
         data_n = '0;
         rpin_n = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         h <= '0;
         rcnt <= '0;
         data <= '0;
         rpin <= 1'b1;
         busy <= 1'b0;
         done <= 1'b0;
         instr_ready <= 1'b1;
         wptr <= '0;
         count <= '0;
         gpo_meta <= '0;
         gpo_out <= '0;
      end else begin
         state <= state_n;
         h <= h_n;
         rcnt <= rcnt_n;
         data <= data_n;
         rpin <= rpin_n;
         busy <= state_n == RESET || state_n == LOAD;
         done <= state_n == RUN;
         instr_ready <= state_n == IDLE && count_n < 4'd8;
         wptr <= wr ? wptr + 1'b1 : wptr;
         count <= count_n;
         gpo_meta <= pin_in[3:0];
         gpo_out <= gpo_meta;
      end
   end
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= instr_data;
   end
endmodule
